mem_access_unit: RTL and testbench

//  Load/store front-end between the pipeline MEM stage and datamem. Accepts one byte/half/word

---
 rtl/mem_access_unit_pkg.sv | 39 +++
 rtl/mem_access_unit_lane_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Purpose: shared widths, size/fault codes and FSM states for the load/store front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_unit_pkg;

  localparam int WORD_LEN      = 32;
  localparam int DATA_MEM_SIZE = 64;                 // words backed by datamem
  localparam int DM_BYTES_DEF  = 4 * DATA_MEM_SIZE;

  typedef enum logic [1:0] {
    MEM_SZ_B = 2'b00,
    MEM_SZ_H = 2'b01,
    MEM_SZ_W = 2'b10,
    MEM_SZ_X = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    MEM_FLT_OK  = 2'b00,
    MEM_FLT_MIS = 2'b01,
    MEM_FLT_OOR = 2'b10
  } mem_fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } mau_state_e;

  // Number of bytes touched by an access of the given size (illegal size faults first anyway).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_SZ_B: size_bytes = 3'd1;
      MEM_SZ_H: size_bytes = 3'd2;
      default:  size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Purpose: little-endian lane select with sign/zero extension for loads, lane merge for stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [WORD_LEN-1:0] word,
  input  logic [1:0]          addr_lo,
  input  logic [1:0]          size,
  input  logic                sgn,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] ld_val,
  output logic [WORD_LEN-1:0] st_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed lane(s) out of the word and build both load and merged-store views.
  always_comb begin
    lane_b  = word[{addr_lo, 3'b000} +: 8];
    lane_h  = addr_lo[1] ? word[16 +: 16] : word[0 +: 16];
    ld_val  = word;
    st_word = word;
    case (size)
      MEM_SZ_B: begin
        ld_val = {{(WORD_LEN-8){sgn & lane_b[7]}}, lane_b};
        st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      MEM_SZ_H: begin
        ld_val = {{(WORD_LEN-16){sgn & lane_h[15]}}, lane_h};
        if (addr_lo[1]) st_word[16 +: 16] = wdata[15:0];
        else            st_word[0 +: 16]  = wdata[15:0];
      end
      default: begin
        ld_val  = word;
        st_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: one-at-a-time byte/half/word load/store front-end to a word-only datamem, RMW for sub-word stores.
// Latency: fault 1 cycle, load/word store 2 cycles, sub-word store 3 cycles from accept to resp_valid.
// Backpressure: req_ready only in IDLE; no queueing, requester holds req_valid until accepted.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int W        = WORD_LEN,
  parameter int DM_BYTES = DM_BYTES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [W-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         resp_valid,
  output logic [W-1:0] resp_rdata,
  output logic [1:0]   resp_fault,
  output logic [W-1:0] dm_addr,
  output logic [W-1:0] dm_wdata,
  output logic         dm_we,
  output logic         dm_re,
  input  logic [W-1:0] dm_rdata
);

  mau_state_e   state_q, state_d;
  logic [W-1:0] addr_q, addr_d;
  logic [1:0]   size_q, size_d;
  logic         sgn_q, sgn_d;
  logic         write_q, write_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [W-1:0] wword_q, wword_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic [1:0]   fault_q, fault_d;
  logic         fwd_valid_q, fwd_valid_d;
  logic [W-3:0] fwd_idx_q, fwd_idx_d;
  logic [W-1:0] fwd_data_q, fwd_data_d;

  logic [2:0]   nbytes;
  logic [W:0]   last_byte;
  logic         mis, oor;
  logic [W-1:0] cap_word, ld_val, st_word;

  // Classify the incoming request; misalignment is checked first and wins over range.
  always_comb begin
    nbytes    = size_bytes(req_size);
    last_byte = {1'b0, req_addr} + {{(W-2){1'b0}}, nbytes} - {{W{1'b0}}, 1'b1};
    mis       = (req_size == MEM_SZ_X) ||
                ((req_size == MEM_SZ_H) && req_addr[0]) ||
                ((req_size == MEM_SZ_W) && (req_addr[1:0] != 2'b00));
    oor       = (last_byte >= (W+1)'(DM_BYTES));
  end

  // datamem only refreshes its output on an address change, so a word we just wrote is taken from
  // the forward register instead of the possibly stale dm_rdata.
  always_comb begin
    cap_word = (fwd_valid_q && (fwd_idx_q == addr_q[W-1:2])) ? fwd_data_q : dm_rdata;
  end

  mem_lane_align u_lane (
    .word    (cap_word),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .sgn     (sgn_q),
    .wdata   (wdata_q),
    .ld_val  (ld_val),
    .st_word (st_word)
  );

  // Next-state and request/forward register updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wword_d     = wword_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    fwd_valid_d = fwd_valid_q;
    fwd_idx_d   = fwd_idx_q;
    fwd_data_d  = fwd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          sgn_d   = req_signed;
          write_d = req_write;
          wdata_d = req_wdata;
          rdata_d = '0;
          fault_d = MEM_FLT_OK;
          if (mis) begin
            fault_d = MEM_FLT_MIS;
            state_d = ST_RESP;
          end else if (oor) begin
            fault_d = MEM_FLT_OOR;
            state_d = ST_RESP;
          end else if (!req_write) begin
            state_d = ST_RD;
          end else if (req_size == MEM_SZ_W) begin
            wword_d = req_wdata;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (write_q) begin
          wword_d = st_word;
          state_d = ST_WR;
        end else begin
          rdata_d = ld_val;
          state_d = ST_RESP;
        end
      end
      ST_WR: begin
        fwd_valid_d = 1'b1;
        fwd_idx_d   = addr_q[W-1:2];
        fwd_data_d  = wword_q;
        state_d     = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request and forward registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wword_q     <= '0;
      rdata_q     <= '0;
      fault_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wword_q     <= wword_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_idx_q   <= fwd_idx_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  // Outputs decode registered state only, never the live request.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_fault = resp_valid ? fault_q : 2'b00;
    dm_addr    = {addr_q[W-1:2], 2'b00};
    dm_wdata   = wword_q;
    dm_we      = (state_q == ST_WR);
    dm_re      = (state_q == ST_RD);
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: directed + random check of mem_access_unit against an array-based memory model.
// Latency: checks accept-to-response cycle counts per request type.
// Backpressure: holds req_valid until response and counts accepts.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int DMB = DM_BYTES_DEF;
  localparam int NW  = DMB / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_we, dm_re;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // datamem: output refreshes only on address change (or an explicit preload refresh).
  logic [31:0] dmem    [0:NW-1];
  logic [31:0] ref_mem [0:NW-1];
  int refresh_n = 0;
  always @(dm_addr or refresh_n) begin
    if (dm_addr < 32'(DMB)) dm_rdata = dmem[dm_addr[7:2]];
    else                    dm_rdata = 32'h0;
  end
  always @(posedge clk) if (dm_we && dm_addr < 32'(DMB)) dmem[dm_addr[7:2]] <= dm_wdata;

  int acc_n = 0;
  always @(posedge clk) if (!rst && req_valid && req_ready) acc_n++;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] last_rd;
  logic [1:0]  last_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] exp_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 2'b01;
    if (sz == 2'd1 && (a % 2) != 0) return 2'b01;
    if (sz == 2'd2 && (a % 4) != 0) return 2'b01;
    if (longint'(a) + nbytes_of(sz) > DMB) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    longint v;
    longint w;
    int sh;
    w  = longint'(ref_mem[a / 4]);
    sh = int'(a % 4) * 8;
    if (sz == 2'd2) return ref_mem[a / 4];
    if (sz == 2'd0) begin
      v = (w >> sh) % 256;
      if (sg && v >= 128) v = v - 256;
    end else begin
      v = (w >> sh) % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    int ln;
    w = ref_mem[a / 4];
    for (int k = 0; k < nbytes_of(sz); k++) begin
      ln = int'(a % 4) + k;
      w  = (w & ~(32'hFF << (8 * ln))) | (((d >> (8 * k)) & 32'hFF) << (8 * ln));
    end
    ref_mem[a / 4] = w;
  endtask

  // One request, issued at a negedge; req_valid held until the response is seen.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [1:0]  ef;
    logic [31:0] erd;
    int lat, we_n, re_n, rdy_hi, acc0, wait_n, elat;
    logic got;
    ef  = exp_fault(sz, a);
    erd = (wr || ef != 2'b00) ? 32'h0 : exp_load(sz, sg, a);
    elat = (ef != 2'b00) ? 1 : (!wr || sz == 2'd2) ? 2 : 3;
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
    chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
    acc0 = acc_n;
    lat = 0; we_n = 0; re_n = 0; rdy_hi = 0; got = 1'b0;
    last_rd = 32'hx; last_f = 2'bx;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (dm_we) we_n++;
      if (dm_re) re_n++;
      if (req_ready) rdy_hi++;
      if (resp_valid) begin
        got = 1'b1; last_rd = resp_rdata; last_f = resp_fault;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk({tag, " got_resp"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " rdata"}, last_rd, erd);
    chk({tag, " fault"}, 32'(last_f), 32'(ef));
    chk({tag, " we_cycles"}, 32'(we_n), (ef == 2'b00 && wr) ? 32'd1 : 32'd0);
    chk({tag, " re_cycles"}, 32'(re_n), (ef == 2'b00 && (!wr || sz != 2'd2)) ? 32'd1 : 32'd0);
    chk({tag, " ready_busy"}, 32'(rdy_hi), 32'd0);
    chk({tag, " accepts"}, 32'(acc_n - acc0), 32'd1);
    if (wr && ef == 2'b00) ref_store(sz, a, d);
    @(negedge clk);
    chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
    if (wr && ef == 2'b00) chk({tag, " mem_word"}, dmem[a / 4], ref_mem[a / 4]);
  endtask

  initial begin
    int wait_n;
    int saw_resp;
    logic [31:0] a;
    logic [1:0]  sz;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < NW; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    refresh_n++;
    #1;
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_fault", 32'(resp_fault), 32'd0);
    chk("rst dm_we", 32'(dm_we), 32'd0);
    chk("rst dm_re", 32'(dm_re), 32'd0);
    chk("rst dm_addr", dm_addr, 32'd0);
    chk("rst dm_wdata", dm_wdata, 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Byte loads with both extensions.
    dmem[0] = 32'h8081_7F01; ref_mem[0] = 32'h8081_7F01; refresh_n++;
    do_req(1'b0, 2'd0, 1'b1, 32'h0, 32'h0, "lb0");  chk("lb0 val", last_rd, 32'h0000_0001);
    do_req(1'b0, 2'd0, 1'b1, 32'h1, 32'h0, "lb1");  chk("lb1 val", last_rd, 32'h0000_007F);
    do_req(1'b0, 2'd0, 1'b0, 32'h3, 32'h0, "lbu3"); chk("lbu3 val", last_rd, 32'h0000_0080);
    do_req(1'b0, 2'd0, 1'b1, 32'h3, 32'h0, "lb3");  chk("lb3 val", last_rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, "lh2");  chk("lh2 val", last_rd, 32'hFFFF_8081);

    // Back-to-back sub-word stores to one word, then load through the forward path.
    dmem[1] = 32'hAABB_CCDD; ref_mem[1] = 32'hAABB_CCDD; refresh_n++;
    do_req(1'b1, 2'd0, 1'b0, 32'h6, 32'h0000_0011, "sb6"); chk("sb6 word", dmem[1], 32'hAA11_CCDD);
    do_req(1'b1, 2'd1, 1'b0, 32'h4, 32'h0000_2233, "sh4");
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw4");         chk("lw4 fwd", last_rd, 32'hAA11_2233);
    chk("lw4 dm_addr", dm_addr, 32'h4);

    // Faults.
    do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, "lh3");           chk("lh3 flt", 32'(last_f), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'(DMB), 32'h0, "lw_oor");     chk("lw_oor flt", 32'(last_f), 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'(DMB + 1), 32'h0, "lw_mis"); chk("lw_mis flt", 32'(last_f), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, "sz3");           chk("sz3 flt", 32'(last_f), 32'd1);
    do_req(1'b1, 2'd1, 1'b0, 32'(DMB - 2), 32'h5555, "sh_top"); chk("sh_top flt", 32'(last_f), 32'd0);
    do_req(1'b1, 2'd1, 1'b0, 32'(DMB - 1), 32'h5555, "sh_mis"); chk("sh_mis flt", 32'(last_f), 32'd1);

    // Word store and readback.
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, "sw8");
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "lw8"); chk("lw8 val", last_rd, 32'hDEAD_BEEF);

    // Reset in the middle of a read-modify-write's write cycle.
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, "sw20");
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h21; req_wdata = 32'h99;
    req_valid = 1'b1;
    wait_n = 0;
    while (!dm_we && wait_n < 10) begin @(negedge clk); wait_n++; end
    chk("rstwr saw_we", 32'(dm_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwr dm_we", 32'(dm_we), 32'd0);
    chk("rstwr resp_valid", 32'(resp_valid), 32'd0);
    chk("rstwr dm_addr", dm_addr, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw_resp = 0;
    repeat (3) begin @(negedge clk); if (resp_valid) saw_resp++; end
    chk("rstwr no_resp", 32'(saw_resp), 32'd0);
    chk("rstwr ready", 32'(req_ready), 32'd1);
    chk("rstwr word", dmem[8], 32'h1234_5678);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw20"); chk("lw20 val", last_rd, 32'h1234_5678);

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'(DMB - 4) + 32'($urandom_range(0, 7));
      else                           a = 32'($urandom_range(0, 47));
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~32'h1;
        if (sz == 2'd2) a = a & ~32'h3;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
